// File: rtl/dma_pmp_mc.sv
// Multi-channel DMA PMP gatekeeper: PMP-checks every source word, then every destination word, per channel.
// Latency: uncontended channel with length L shows done 2L+5 cycles after start; one shared check per cycle.
// Backpressure: channels queue on a round-robin arbiter; ungranted channels hold their word index and state.
//
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/abort_i/done_i per-channel control;
// length_i/src_addr_i/dst_addr_i per-channel descriptors; status_o per channel {err,done,store_ok,load_ok,busy};
// pmp_addr_o/pmp_access_o/pmp_valid_o drive the shared PMP checker, pmp_allow_i is its same-cycle verdict.

package riscv;
    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;
endpackage

module dma_pmp_mc #(
    parameter int unsigned NR_CHANNELS = 2,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned STRIDE_LOG2 = 3
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NR_CHANNELS-1:0]                 start_i,
    input  logic [NR_CHANNELS-1:0]                 abort_i,
    input  logic [NR_CHANNELS-1:0]                 done_i,
    input  logic [NR_CHANNELS-1:0][LEN_WIDTH-1:0]  length_i,
    input  logic [NR_CHANNELS-1:0][ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NR_CHANNELS-1:0][ADDR_WIDTH-1:0] dst_addr_i,
    output logic [NR_CHANNELS-1:0][4:0]            status_o,
    output logic [ADDR_WIDTH-1:0]                  pmp_addr_o,
    output riscv::pmp_access_t                     pmp_access_o,
    output logic                                   pmp_valid_o,
    input  logic                                   pmp_allow_i
);

    localparam int unsigned PTR_W = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHK_LD = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_CHK_ST = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ABORT  = 3'd6;

    localparam int ST_BUSY     = 0;
    localparam int ST_LOAD_OK  = 1;
    localparam int ST_STORE_OK = 2;
    localparam int ST_DONE     = 3;
    localparam int ST_ERR      = 4;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << STRIDE_LOG2;

    typedef logic [ADDR_WIDTH:0] addr_ext_t;

    logic [2:0]            ch_state [NR_CHANNELS];
    logic [LEN_WIDTH:0]    ch_k     [NR_CHANNELS];
    logic [ADDR_WIDTH-1:0] ch_src   [NR_CHANNELS];
    logic [ADDR_WIDTH-1:0] ch_dst   [NR_CHANNELS];
    logic [NR_CHANNELS-1:0] req;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             gnt_ld;
    logic [ADDR_WIDTH-1:0] gnt_base;
    addr_ext_t        offset;
    addr_ext_t        sum;
    logic             check_ok;

    // Two passes: first the requesters at or above the pointer, then wrap to the bottom.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NR_CHANNELS; i++) begin
            if (!gnt_vld && req[i] && (i >= 32'(ptr_q))) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < NR_CHANNELS; i++) begin
            if (!gnt_vld && req[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // A single adder serves the granted channel; its carry flags a range wrapping past the address space.
    assign gnt_ld   = (ch_state[gnt_idx] == S_CHK_LD);
    assign gnt_base = gnt_ld ? ch_src[gnt_idx] : ch_dst[gnt_idx];
    assign offset   = addr_ext_t'(ch_k[gnt_idx]) << STRIDE_LOG2;
    assign sum      = {1'b0, gnt_base} + offset;
    assign check_ok = pmp_allow_i && !sum[ADDR_WIDTH];

    assign pmp_valid_o  = gnt_vld;
    assign pmp_addr_o   = gnt_vld ? sum[ADDR_WIDTH-1:0] : '0;
    assign pmp_access_o = (gnt_vld && !gnt_ld) ? riscv::ACCESS_WRITE : riscv::ACCESS_READ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (gnt_vld) begin
            ptr_q <= (gnt_idx == PTR_W'(NR_CHANNELS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    for (genvar c = 0; c < NR_CHANNELS; c++) begin : g_ch
        logic [2:0]            state_q;
        logic [LEN_WIDTH:0]    k_q;
        logic [LEN_WIDTH-1:0]  len_q;
        logic [ADDR_WIDTH-1:0] src_q;
        logic [ADDR_WIDTH-1:0] dst_q;
        logic [4:0]            stat_q;
        logic                  granted;
        logic                  last_word;

        assign granted     = gnt_vld && (gnt_idx == PTR_W'(c));
        assign last_word   = (k_q == {1'b0, len_q});
        assign req[c]      = (state_q == S_CHK_LD) || (state_q == S_CHK_ST);
        assign ch_state[c] = state_q;
        assign ch_k[c]     = k_q;
        assign ch_src[c]   = src_q;
        assign ch_dst[c]   = dst_q;
        assign status_o[c] = stat_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= S_IDLE;
                k_q     <= '0;
                len_q   <= '0;
                src_q   <= '0;
                dst_q   <= '0;
                stat_q  <= '0;
            end else if (abort_i[c] && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
                // Abort wins over everything, including a check granted this cycle.
                state_q         <= S_ABORT;
                stat_q[ST_ERR]  <= 1'b1;
                stat_q[ST_BUSY] <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i[c]) begin
                            len_q   <= length_i[c];
                            src_q   <= src_addr_i[c] & ALIGN_MASK;
                            dst_q   <= dst_addr_i[c] & ALIGN_MASK;
                            k_q     <= '0;
                            stat_q  <= 5'b00001;
                            state_q <= S_CHK_LD;
                        end
                    end
                    S_CHK_LD, S_CHK_ST: begin
                        if (granted) begin
                            if (!check_ok) begin
                                state_q         <= S_DONE;
                                stat_q[ST_ERR]  <= 1'b1;
                                stat_q[ST_DONE] <= 1'b1;
                                stat_q[ST_BUSY] <= 1'b0;
                            end else if (last_word) begin
                                if (state_q == S_CHK_LD) begin
                                    state_q            <= S_LOAD;
                                    stat_q[ST_LOAD_OK] <= 1'b1;
                                end else begin
                                    state_q             <= S_STORE;
                                    stat_q[ST_STORE_OK] <= 1'b1;
                                end
                            end else begin
                                k_q <= k_q + (LEN_WIDTH + 1)'(1);
                            end
                        end
                    end
                    S_LOAD: begin
                        k_q     <= '0;
                        state_q <= S_CHK_ST;
                    end
                    S_STORE: begin
                        state_q         <= S_DONE;
                        stat_q[ST_DONE] <= 1'b1;
                        stat_q[ST_BUSY] <= 1'b0;
                    end
                    S_DONE: begin
                        // Status is left in place so software can read it until the next start.
                        if (done_i[c]) state_q <= S_IDLE;
                    end
                    S_ABORT: begin
                        if (done_i[c]) begin
                            state_q         <= S_DONE;
                            stat_q[ST_DONE] <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule
